// File: rtl/riscv_core_dcache_controller.sv
// L1 data cache sequencer: direct-mapped, 32-byte lines, write-through,
// no-write-allocate; owns tag/valid state and drives data-memory and AXI requests.
module riscv_core_dcache_controller #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INDEX_WIDTH = 7,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    input  logic                  i_req_wr,
    input  logic                  i_req_amo,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_flush,
    output logic                  o_stall,
    output logic                  o_mem_rd_en,
    output logic                  o_mem_wr_en,
    output logic                  o_mem_amo_wr,
    output logic                  o_mem_block_replace,
    output logic                  o_axi_rd_req,
    output logic                  o_axi_wr_req,
    output logic [ADDR_WIDTH-1:0] o_axi_addr,
    input  logic                  i_axi_rd_done,
    input  logic                  i_axi_wr_done,
    output logic [CNT_WIDTH-1:0]  o_miss_count
);

    localparam int SETS    = 1 << INDEX_WIDTH;
    localparam int TAG_LSB = 5 + INDEX_WIDTH;
    localparam int TAG_W   = ADDR_WIDTH - TAG_LSB;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        AMO_WR,
        WTHRU
    } state_t;

    state_t            state;
    logic [SETS-1:0]   valid;
    logic [TAG_W-1:0]  tags [SETS];

    logic [INDEX_WIDTH-1:0] idx;
    logic [TAG_W-1:0]       tag;
    logic                   hit;
    logic                   rd_type;
    logic                   refill_done;

    assign idx     = i_addr[TAG_LSB-1:5];
    assign tag     = i_addr[ADDR_WIDTH-1:TAG_LSB];
    assign hit     = valid[idx] && (tags[idx] == tag);
    // AMOs take the load path first: they need the line resident to read an operand
    assign rd_type = !i_req_wr || i_req_amo;
    assign refill_done = (state == REFILL) && i_axi_rd_done;

    always_comb begin
        o_stall             = 1'b0;
        o_mem_rd_en         = 1'b0;
        o_mem_wr_en         = 1'b0;
        o_mem_amo_wr        = 1'b0;
        o_mem_block_replace = 1'b0;
        o_axi_rd_req        = 1'b0;
        o_axi_wr_req        = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_flush) begin
                    o_stall = i_req_valid;
                end else if (i_req_valid) begin
                    if (rd_type) begin
                        o_mem_rd_en = hit;
                        o_stall     = !hit || i_req_amo;
                    end else begin
                        o_mem_wr_en = hit;
                        o_stall     = 1'b1;
                    end
                end
            end
            REFILL: begin
                o_stall             = 1'b1;
                o_axi_rd_req        = 1'b1;
                o_mem_wr_en         = i_axi_rd_done;
                o_mem_block_replace = i_axi_rd_done;
            end
            AMO_WR: begin
                o_stall      = 1'b1;
                o_mem_wr_en  = 1'b1;
                o_mem_amo_wr = 1'b1;
            end
            WTHRU: begin
                o_axi_wr_req = 1'b1;
                o_stall      = !i_axi_wr_done;
            end
        endcase
    end

    always_comb begin
        o_axi_addr = '0;
        if (o_axi_rd_req)
            o_axi_addr = {i_addr[ADDR_WIDTH-1:5], 5'b0};
        else if (o_axi_wr_req)
            o_axi_addr = i_addr;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            valid        <= '0;
            o_miss_count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_flush) begin
                        valid <= '0;
                    end else if (i_req_valid) begin
                        if (rd_type && !hit) begin
                            state <= REFILL;
                            if (o_miss_count != '1)
                                o_miss_count <= o_miss_count + 1'b1;
                        end else if (rd_type && i_req_amo) begin
                            state <= AMO_WR;
                        end else if (!rd_type) begin
                            state <= WTHRU;
                        end
                    end
                end
                REFILL: begin
                    if (i_axi_rd_done) begin
                        valid[idx] <= 1'b1;
                        state      <= IDLE;
                    end
                end
                AMO_WR: state <= WTHRU;
                WTHRU: begin
                    if (i_axi_wr_done)
                        state <= IDLE;
                end
            endcase
        end
    end

    // Tag storage is plain memory; the valid bits alone make it meaningful
    always_ff @(posedge i_clk) begin
        if (refill_done)
            tags[idx] <= tag;
    end

endmodule
